// File: rtl/gpu_pkg.sv
// Shared GPU raster definitions: screen geometry, field widths and the pixel record.
// The framebuffer is row-major, one word per pixel.
package gpu_pkg;
   localparam int WIDTH_BITS   = 10;
   localparam int HEIGHT_BITS  = 9;
   localparam int CHANNEL_BITS = 8;
   localparam int WIDTH        = 640;
   localparam int HEIGHT       = 480;
   localparam int ADDR_BITS    = 19;

   typedef struct packed {
      logic [WIDTH_BITS-1:0]   x;
      logic [HEIGHT_BITS-1:0]  y;
      logic [CHANNEL_BITS-1:0] r;
      logic [CHANNEL_BITS-1:0] g;
      logic [CHANNEL_BITS-1:0] b;
   } pixel_t;

   // Y*640 + X built from two shifts so no multiplier is inferred.
   function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [WIDTH_BITS-1:0]  x,
                                                     input logic [HEIGHT_BITS-1:0] y);
      logic [ADDR_BITS-1:0] yw;
      yw = ADDR_BITS'(y);
      return (yw << 9) + (yw << 7) + ADDR_BITS'(x);
   endfunction
endpackage

// File: rtl/gpu_pixel_fifo.sv
// Small synchronous FIFO of pixel records; full/empty come straight from the
// occupancy register so ready never depends combinationally on a same-cycle pop.
module gpu_pixel_fifo
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic   clk,
   input  logic   n_rst,
   input  logic   push_i,
   input  pixel_t data_i,
   input  logic   pop_i,
   output pixel_t data_o,
   output logic   full_o,
   output logic   empty_o
);
   localparam int PW = $clog2(FIFO_DEPTH);

   pixel_t        mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/gpu_pixel_writer.sv
// Rasterizer pixel sink: clips off-screen pixels, buffers the rest and issues one
// framebuffer write per pixel over a req/ack handshake.
module gpu_pixel_writer
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   input  logic [WIDTH_BITS-1:0]     X,
   input  logic [HEIGHT_BITS-1:0]    Y,
   input  logic [CHANNEL_BITS-1:0]   r_i,
   input  logic [CHANNEL_BITS-1:0]   g_i,
   input  logic [CHANNEL_BITS-1:0]   b_i,
   output logic                      mem_req,
   output logic [ADDR_BITS-1:0]      mem_addr,
   output logic [3*CHANNEL_BITS-1:0] mem_data,
   input  logic                      mem_ack,
   output logic                      busy,
   output logic [7:0]                clip_count
);
   typedef enum logic {IDLE, REQ} state_t;

   state_t                    state_q, state_d;
   logic                      req_q, req_d;
   logic [ADDR_BITS-1:0]      addr_q, addr_d;
   logic [3*CHANNEL_BITS-1:0] data_q, data_d;
   logic [7:0]                clip_q, clip_d;
   logic                      full, empty, pop, accept, in_range;
   pixel_t                    head, pix_in;

   assign pix_in   = '{x: X, y: Y, r: r_i, g: g_i, b: b_i};
   assign in_range = (X < WIDTH_BITS'(WIDTH)) && (Y < HEIGHT_BITS'(HEIGHT));
   assign accept   = pix_valid & pix_ready;

   gpu_pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push_i  (accept & in_range),
      .data_i  (pix_in),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin
            pop     = 1'b1;
            req_d   = 1'b1;
            state_d = REQ;
         end
         REQ: if (mem_ack) begin
            if (!empty) begin
               pop = 1'b1;
            end else begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         addr_d = pix_addr(head.x, head.y);
         data_d = {head.r, head.g, head.b};
      end
   end

   // Off-screen pixels (including the rasterizer idle value) only bump this counter.
   assign clip_d = (accept && !in_range && clip_q != 8'hFF) ? clip_q + 8'd1 : clip_q;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         clip_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         clip_q  <= clip_d;
      end
   end

   assign pix_ready  = ~full;
   assign mem_req    = req_q;
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign busy       = (state_q == REQ) | ~empty;
   assign clip_count = clip_q;
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized handshake soak.
module tb_gpu_pixel_writer;
   logic        clk = 1'b0;
   logic        n_rst, pix_valid, pix_ready, mem_req, mem_ack, busy;
   logic [9:0]  X;
   logic [8:0]  Y;
   logic [7:0]  r_i, g_i, b_i, clip_count;
   logic [18:0] mem_addr;
   logic [23:0] mem_data;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gpu_pixel_writer dut (
      .clk(clk), .n_rst(n_rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .X(X), .Y(Y), .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
      .busy(busy), .clip_count(clip_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of on-screen pixels plus the current write.
   typedef struct { int x; int y; logic [23:0] rgb; } mpix_t;
   mpix_t       mq[$];
   bit          m_req = 0;
   int          m_addr = 0;
   logic [23:0] m_data = '0;
   int          m_clip = 0;

   always @(posedge clk) begin
      bit    acc, can_pop;
      mpix_t p, h;
      if (!n_rst) begin
         mq.delete();
         m_req = 0; m_addr = 0; m_data = '0; m_clip = 0;
      end else begin
         acc     = pix_valid && (mq.size() < 4);
         can_pop = (mq.size() > 0) && (!m_req || mem_ack);
         if (m_req && mem_ack && !can_pop) m_req = 0;
         if (can_pop) begin
            h      = mq.pop_front();
            m_req  = 1;
            m_addr = h.y * 640 + h.x;
            m_data = h.rgb;
         end
         if (acc) begin
            if (int'(X) >= 640 || int'(Y) >= 480) begin
               if (m_clip < 255) m_clip++;
            end else begin
               p.x = int'(X); p.y = int'(Y); p.rgb = {r_i, g_i, b_i};
               mq.push_back(p);
            end
         end
      end
      #1;
      chk("pix_ready", pix_ready, (mq.size() < 4));
      chk("mem_req", mem_req, m_req);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("busy", busy, (m_req || mq.size() > 0));
      chk("clip_count", clip_count, m_clip);
   end

   task automatic drive(input int x, input int y, input logic [23:0] rgb);
      pix_valid = 1'b1;
      X = x[9:0]; Y = y[8:0];
      {r_i, g_i, b_i} = rgb;
   endtask

   initial begin
      int idx, nw;
      bit rdy;
      n_rst = 0; pix_valid = 0; mem_ack = 0; X = 0; Y = 0; r_i = 0; g_i = 0; b_i = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", pix_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clip", clip_count, 0);
      n_rst = 1;

      // single pixel, ack two cycles after request
      drive(3, 2, 24'h112233);
      @(negedge clk); pix_valid = 0;
      chk("t1_latency_req", mem_req, 0);
      @(negedge clk);
      chk("t1_req", mem_req, 1);
      chk("t1_addr", mem_addr, 1283);
      chk("t1_data", mem_data, 24'h112233);
      @(negedge clk);
      chk("t1_hold_req", mem_req, 1);
      chk("t1_hold_addr", mem_addr, 1283);
      mem_ack = 1;
      @(negedge clk); mem_ack = 0;
      chk("t1_done_req", mem_req, 0);
      chk("t1_done_busy", busy, 0);

      // screen corner, then two clipped pixels
      drive(639, 479, 24'hABCDEF);
      @(negedge clk); pix_valid = 0;
      @(negedge clk);
      chk("corner_addr", mem_addr, 307199);
      chk("corner_req", mem_req, 1);
      mem_ack = 1;
      @(negedge clk); mem_ack = 0;
      drive(640, 0, 24'h0);
      @(negedge clk); drive(0, 480, 24'h0);
      @(negedge clk); pix_valid = 0;
      @(negedge clk);
      chk("clip_two", clip_count, 2);
      chk("clip_no_req", mem_req, 0);

      // stall: ack low, six pixels offered
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         rdy = pix_ready;
         if (idx < 6) drive(10 + idx, idx, {8'(idx), 8'h5A, 8'hA5});
         else pix_valid = 0;
         @(negedge clk);
         if (rdy && idx < 6) idx++;
         if (c >= 1) chk("stall_addr_stable", mem_addr, 10);
      end
      pix_valid = 0;
      chk("stall_accepts", idx, 5);
      chk("stall_ready_low", pix_ready, 0);
      mem_ack = 1; nw = 0;
      repeat (8) begin
         if (mem_req) nw++;
         @(negedge clk);
      end
      chk("stall_drain_writes", nw, 5);
      mem_ack = 0;

      // ack tied high, back-to-back pixels
      mem_ack = 1; nw = 0;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) drive(100 + c, 7, 24'h010203 * c);
         else pix_valid = 0;
         if (mem_req) nw++;
         @(negedge clk);
      end
      chk("b2b_writes", nw, 3);
      mem_ack = 0;

      // saturation
      drive(700, 5, 24'h0);
      repeat (300) @(negedge clk);
      pix_valid = 0;
      @(negedge clk);
      chk("clip_sat", clip_count, 255);
      chk("clip_sat_req", mem_req, 0);
      chk("clip_sat_busy", busy, 0);

      // reset while a request and three queued pixels are pending
      for (int c = 0; c < 4; c++) begin
         drive(20 + c, 30, 24'hFFFFFF);
         @(negedge clk);
      end
      pix_valid = 0;
      chk("pre_rst_req", mem_req, 1);
      n_rst = 0;
      @(negedge clk);
      n_rst = 1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", pix_ready, 1);
      chk("mid_rst_clip", clip_count, 0);
      mem_ack = 1; nw = 0;
      repeat (5) begin
         if (mem_req) nw++;
         @(negedge clk);
      end
      chk("mid_rst_no_writes", nw, 0);

      // randomized soak
      for (int c = 0; c < 2000; c++) begin
         pix_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            X = 10'($urandom_range(0, 1023));
            Y = 9'($urandom_range(0, 511));
         end else begin
            X = 10'($urandom_range(0, 639));
            Y = 9'($urandom_range(0, 479));
         end
         {r_i, g_i, b_i} = 24'($urandom);
         mem_ack = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      pix_valid = 0; mem_ack = 1;
      repeat (10) @(negedge clk);
      chk("soak_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
